// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Shared state encoding and command opcodes for the SPI target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    WR_DATA = 3'd3,
    RD_LOAD = 3'd4,
    RD_DATA = 3'd5,
    IGNORE  = 3'd6
  } spi_state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

endpackage

`default_nettype wire

// File: rtl/spi_edge_sync.sv
// ============================================================================
// Module : spi_edge_sync
// Brief  : Multi-flop synchronizer with rise/fall detection on the synced level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic w_sync;
  logic r_prev;

  generate
    if (SYNC_STAGES <= 1) begin : g_single
      logic r_s;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s <= 1'b0;
        else        r_s <= din;
      end
      assign w_sync = r_s;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] r_s;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s <= '0;
        else        r_s <= {r_s[SYNC_STAGES-2:0], din};
      end
      assign w_sync = r_s[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_sync;
  end

  assign q    = w_sync;
  assign rise = w_sync & ~r_prev;
  assign fall = ~w_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_target.sv
// ============================================================================
// Module : spi_target
// Brief  : SPI mode-0 target bridging write (0x02) / read (0x03) frames to a
//          byte memory. Define SPI_TARGET_CMD_ERR_EN to enable cmd_err pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_target
  import spi_pkg::*;
#(
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int SYNC_STAGES          = 2,
  localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          cmd_err
);

  localparam logic [AW-1:0] c_addr_one = AW'(1);

  logic w_sclk_unused, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_cs_q, w_cs_rise, w_cs_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .q(w_sclk_unused), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .q(w_mosi), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .q(w_cs_q), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_state_t      r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_rx_sh, r_tx_sh;
  logic [AW-1:0]   r_addr;
  logic            r_is_read, r_miso, r_mem_we;
  logic [7:0]      r_mem_wdata;

  logic       w_sclk_rise_act, w_sclk_fall_act, w_byte_done, w_cmd_known;
  logic [7:0] w_rx_byte;

  // sclk edges only count while the synchronized select is low
  assign w_sclk_rise_act = w_sclk_rise & ~w_cs_q;
  assign w_sclk_fall_act = w_sclk_fall & ~w_cs_q;
  assign w_rx_byte       = {r_rx_sh[6:0], w_mosi};
  assign w_byte_done     = w_sclk_rise_act & (r_bit_cnt == 3'd7) & ~w_cs_rise;
  assign w_cmd_known     = (w_rx_byte == CMD_WRITE) || (w_rx_byte == CMD_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall)   w_state_nxt = CMD;
        CMD:     if (w_byte_done) w_state_nxt = w_cmd_known ? ADDR : IGNORE;
        ADDR:    if (w_byte_done) w_state_nxt = r_is_read ? RD_LOAD : WR_DATA;
        RD_LOAD: w_state_nxt = RD_DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // The write address stays on mem_addr for the strobe cycle, then steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_rx_sh     <= 8'h00;
      r_tx_sh     <= 8'h00;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_miso      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'h00;
    end else begin
      r_mem_we <= 1'b0;
      if (r_mem_we) r_addr <= r_addr + c_addr_one;

      if (w_cs_rise) begin
        r_bit_cnt <= 3'd0;
        r_rx_sh   <= 8'h00;
        r_tx_sh   <= 8'h00;
        r_miso    <= 1'b0;
      end else begin
        if (w_sclk_rise_act) begin
          r_rx_sh   <= w_rx_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_sclk_fall_act) begin
          r_miso  <= r_tx_sh[7];
          r_tx_sh <= {r_tx_sh[6:0], 1'b0};
        end
        case (r_state)
          IDLE: if (w_cs_fall) begin
            r_bit_cnt <= 3'd0;
            r_rx_sh   <= 8'h00;
            r_tx_sh   <= 8'h00;
            r_miso    <= 1'b0;
          end
          CMD:     if (w_byte_done) r_is_read <= (w_rx_byte == CMD_READ);
          ADDR:    if (w_byte_done) r_addr <= w_rx_byte[AW-1:0];
          WR_DATA: if (w_byte_done) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_rx_byte;
          end
          RD_LOAD: begin
            r_tx_sh <= mem_rdata;
            r_addr  <= r_addr + c_addr_one;
          end
          RD_DATA: if (w_byte_done) begin
            r_tx_sh <= mem_rdata;
            r_addr  <= r_addr + c_addr_one;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_TARGET_CMD_ERR_EN
  logic r_cmd_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cmd_err <= 1'b0;
    else        r_cmd_err <= (r_state == CMD) && w_byte_done && !w_cmd_known;
  end
  assign cmd_err = r_cmd_err;
`else
  assign cmd_err = 1'b0;
`endif

  assign miso      = ((r_state == RD_LOAD) || (r_state == RD_DATA)) ? r_miso : 1'b0;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
// ============================================================================
// Module : tb_spi_target
// Brief  : Directed self-checking bench for spi_target with a byte memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_target;

  localparam int MEM_SIZE = 64;
  localparam int SYNC     = 2;
  localparam int AW       = $clog2(MEM_SIZE);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          cmd_err;

  spi_target #(.MEMORY_SIZE_IN_BYTES(MEM_SIZE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MEM_SIZE];
  int         log_addr[$];
  logic [7:0] log_data[$];
  int         cmd_err_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      log_addr.push_back(int'(mem_addr));
      log_data.push_back(mem_wdata);
    end
    if (cmd_err === 1'b1) cmd_err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One mode-0 transfer of n bits, MSB first; miso is sampled on each rise
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #40 sclk = 1'b1;
      rx[7-i] = miso;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #40 cs_n = 1'b1;
    #120;
  endtask

  logic [7:0] rx0, rx1, rx2, rx3;
  int         err_exp;

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i + 8'h80);
`ifdef SPI_TARGET_CMD_ERR_EN
    err_exp = 1;
`else
    err_exp = 0;
`endif
    #2;
    #40;
    check("rst_miso",  32'(miso), 32'h0);
    check("rst_addr",  32'(mem_addr), 32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    check("rst_we",    32'(mem_we), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_err",   32'(cmd_err), 32'h0);
    rst_n = 1'b1;
    #100;

    // Write 02,05,A1,B2
    log_addr.delete(); log_data.delete();
    cs_low();
    spi_bits(8'h02, 8, rx0);
    spi_bits(8'h05, 8, rx1);
    check("wr_busy", 32'(busy), 32'h1);
    spi_bits(8'hA1, 8, rx2);
    spi_bits(8'hB2, 8, rx3);
    cs_high();
    check("wr_miso", {rx0, rx1, rx2, rx3}, 32'h0);
    check("wr_count", 32'(log_addr.size()), 32'd2);
    check("wr0", {log_addr[0][15:0], 8'h00, log_data[0]}, {16'd5, 8'h00, 8'hA1});
    check("wr1", {log_addr[1][15:0], 8'h00, log_data[1]}, {16'd6, 8'h00, 8'hB2});
    check("wr_idle", 32'(busy), 32'h0);

    // Read 03,0A,xx,xx with mem[10..11]=3C,C3
    mem[10] = 8'h3C; mem[11] = 8'hC3;
    log_addr.delete(); log_data.delete();
    cs_low();
    spi_bits(8'h03, 8, rx0);
    spi_bits(8'h0A, 8, rx1);
    spi_bits(8'hFF, 8, rx2);
    spi_bits(8'h00, 8, rx3);
    cs_high();
    check("rd_bytes", {rx0, rx1, rx2, rx3}, 32'h00003CC3);
    check("rd_addr_end", 32'(mem_addr), 32'd13);
    check("rd_no_write", 32'(log_addr.size()), 32'd0);

    // Address wrap 02,3F,11,22
    log_addr.delete(); log_data.delete();
    cs_low();
    spi_bits(8'h02, 8, rx0);
    spi_bits(8'h3F, 8, rx1);
    spi_bits(8'h11, 8, rx2);
    spi_bits(8'h22, 8, rx3);
    cs_high();
    check("wrap_count", 32'(log_addr.size()), 32'd2);
    check("wrap0", {log_addr[0][15:0], 8'h00, log_data[0]}, {16'd63, 8'h00, 8'h11});
    check("wrap1", {log_addr[1][15:0], 8'h00, log_data[1]}, {16'd0, 8'h00, 8'h22});
    check("wrap_addr_end", 32'(mem_addr), 32'd1);

    // Abort: 02,00 then 5 bits, then deselect
    log_addr.delete(); log_data.delete();
    cs_low();
    spi_bits(8'h02, 8, rx0);
    spi_bits(8'h00, 8, rx1);
    spi_bits(8'hFF, 5, rx2);
    #40;
    check("abort_busy_before", 32'(busy), 32'h1);
    cs_n = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    check("abort_busy_after", 32'(busy), 32'h0);
    check("abort_miso", 32'(miso), 32'h0);
    #101;
    check("abort_no_write", 32'(log_addr.size()), 32'd0);

    // Unknown command 0x7E
    log_addr.delete(); log_data.delete();
    cmd_err_cnt = 0;
    cs_low();
    spi_bits(8'h7E, 8, rx0);
    spi_bits(8'h02, 8, rx1);
    check("bad_busy", 32'(busy), 32'h1);
    spi_bits(8'h55, 8, rx2);
    cs_high();
    check("bad_err_cnt", 32'(cmd_err_cnt), 32'(err_exp));
    check("bad_miso", {8'h00, rx0, rx1, rx2}, 32'h0);
    check("bad_no_write", 32'(log_addr.size()), 32'd0);

    // Reset during byte 3 of a read
    log_addr.delete(); log_data.delete();
    cmd_err_cnt = 0;
    cs_low();
    spi_bits(8'h03, 8, rx0);
    spi_bits(8'h10, 8, rx1);
    spi_bits(8'h00, 4, rx2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso",  32'(miso), 32'h0);
    check("mid_rst_addr",  32'(mem_addr), 32'h0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'h0);
    check("mid_rst_we",    32'(mem_we), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_err",   32'(cmd_err), 32'h0);
    #19 rst_n = 1'b1;
    #40;
    spi_bits(8'h02, 8, rx0);
    spi_bits(8'h01, 8, rx1);
    check("post_rst_no_frame", 32'(busy), 32'h0);
    cs_high();
    check("post_rst_no_write", 32'(log_addr.size()), 32'd0);
    cs_low();
    spi_bits(8'h02, 8, rx0);
    spi_bits(8'h01, 8, rx1);
    spi_bits(8'h55, 8, rx2);
    cs_high();
    check("fresh_count", 32'(log_addr.size()), 32'd1);
    check("fresh_wr", {log_addr[0][15:0], 8'h00, log_data[0]}, {16'd1, 8'h00, 8'h55});
    check("fresh_mem", 32'(mem[1]), 32'h55);
    check("fresh_err", 32'(cmd_err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter MEMORY_SIZE_IN_BYTES, default 64, meaning the size of the attached byte memory; AW = $clog2(MEMORY_SIZE_IN_BYTES).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sclk, mosi and cs_n.
REQ-003 SHALL have port clk  input  1  system clock, at least 4x the sclk frequency.
REQ-004 SHALL have port rst_n  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port sclk  input  1  SPI clock from the initiator (CPOL=0, CPHA=0).
REQ-006 SHALL have port cs_n  input  1  chip select, active-low.
REQ-007 SHALL have port mosi  input  1  serial data from the initiator, MSB first.
REQ-008 SHALL have port miso  output  1  serial data to the initiator, MSB first.
REQ-009 SHALL have port mem_addr  output  AW  memory byte address.
REQ-010 SHALL have port mem_wdata  output  8  memory write data.
REQ-011 SHALL have port mem_we  output  1  memory write strobe, one clk wide.
REQ-012 SHALL have port mem_rdata  input  8  memory read data, combinational from mem_addr.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port cmd_err  output  1  one-clk pulse on an unknown command byte.

Function
REQ-015 SHALL synchronize sclk, mosi and cs_n through SYNC_STAGES flops and detect sclk rise/fall and cs_n fall/rise from the synchronized values.
REQ-016 SHALL sample synchronized mosi into an 8-bit receive shift register on each detected sclk rise while cs_n is low.
REQ-017 SHALL update miso from the transmit shift register MSB on each detected sclk fall, and on a detected cs_n fall.
REQ-018 SHALL use states IDLE, CMD, ADDR, WR_DATA, RD_LOAD, RD_DATA and IGNORE.
REQ-019 SHALL transition IDLE->CMD on a cs_n fall, and clear the bit counter to 0 and the transmit register to 0x00.
REQ-020 SHALL, on the 8th rise in CMD, go to ADDR for 0x02 (write) or 0x03 (read); for any other byte it SHALL go to IGNORE and pulse cmd_err.
REQ-021 SHALL, on the 8th rise in ADDR, latch receive bits [AW-1:0] into the address register; upper bits are ignored.
REQ-022 SHALL, after the address byte, go to WR_DATA for a write, or to RD_LOAD for a read.
REQ-023 SHALL, in WR_DATA on each 8th rise, assert mem_we for one clk with mem_addr = address and mem_wdata = received byte, then increment the address.
REQ-024 SHALL, in RD_LOAD, load the transmit register from mem_rdata at the current address, increment the address, and go to RD_DATA within one clk.
REQ-025 SHALL, in RD_DATA on each 8th rise, reload the transmit register from mem_rdata at the address and increment, so bit 7 appears on the next sclk fall.
REQ-026 SHALL wrap address increments modulo MEMORY_SIZE_IN_BYTES (AW bits, no carry).
REQ-027 SHALL drive miso 0 in IDLE, CMD, ADDR and IGNORE.
REQ-028 SHALL, on a cs_n rise in any state, return to IDLE within one clk, discard any partial byte with no mem_we, and drive miso 0.
REQ-029 SHALL ignore sclk edges while cs_n is high.
REQ-030 SHALL take the cs_n rise when a cs_n rise and an 8th sclk rise are detected in the same clk, so no write occurs.

Reset
REQ-031 SHALL, while rst_n is low, hold state IDLE, miso 0, mem_addr 0, mem_wdata 0, mem_we 0, busy 0, cmd_err 0, shift registers 0, bit counter 0 and synchronizers 0.
REQ-032 SHALL, on reset mid-transaction, abandon the transaction and require a fresh cs_n fall after reset release.

Configuration
REQ-033 SHALL use macro SPI_TARGET_CMD_ERR_EN: when defined, cmd_err pulses per REQ-020; when undefined, cmd_err is tied 0 and unknown commands still go to IGNORE.

Structure
REQ-034 SHALL place the state enum typedef and the CMD_WRITE=8'h02 and CMD_READ=8'h03 constants in shared package spi_pkg.
REQ-035 SHALL implement synchronization and edge detection in one sub-module, spi_edge_sync, instantiated per input.

Verification
REQ-036 SHALL verify: frame 02,05,A1,B2 -> mem_we pulses twice, with (addr 5, A1) then (addr 6, B2).
REQ-037 SHALL verify: memory[10..11]=3C,C3; frame 03,0A,xx,xx -> miso bytes 00,00,3C,C3.
REQ-038 SHALL verify: write 02,3F,11,22 with size 64 -> writes to addr 63 then addr 0.
REQ-039 SHALL verify: frame 02,00 plus 5 bits then cs_n high -> no mem_we, and busy returns to 0 within SYNC_STAGES+2 clk.
REQ-040 SHALL verify: command 0x7E -> one cmd_err pulse with the macro defined, zero pulses without it, miso 0 and no mem_we either way.
REQ-041 SHALL verify: rst_n low during byte 3 of a read -> all outputs take their reset values, and the next frame 02,01,55 writes 55 to addr 1.
